mux_scan_sequencer: RTL and testbench

//  Drives the 3-bit select of the 8:1 mux (mux81) through channels 0..7 and samples its

---
 rtl/mux_scan_defs_pkg.sv | 26 ++
 rtl/mux_scan_sequencer_dwell_timer.sv | 38 +++
 rtl/mux_scan_sequencer.sv | 123 ++++++++++++
 tb/tb_mux_scan_sequencer.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/mux_scan_defs_pkg.sv
// Shared definitions for the mux scan sequencer: state encoding, channel
// geometry and a small bit-insertion helper used when assembling a scan.
package mux_scan_defs;

   localparam int SEL_W = 3;
   localparam int NCH   = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Return v with bit idx replaced by b.
   function automatic logic [NCH-1:0] set_bit(
      input logic [NCH-1:0]   v,
      input logic [SEL_W-1:0] idx,
      input logic             b
   );
      logic [NCH-1:0] r;
      r      = v;
      r[idx] = b;
      return r;
   endfunction

endpackage

// File: rtl/mux_scan_sequencer_dwell_timer.sv
// Dwell timer: counts the cycles a select value has been held and flags the
// last one, which is the cycle on which the mux output is sampled.
module dwell_timer #(
   parameter int DWELL = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int            CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] LAST = CW'(DWELL - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic [CW-1:0] cnt_r;

   // Cycle counter: cleared outside a scan, wraps to zero after the last dwell cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= {CW{1'b0}};
      end else if (clr) begin
         cnt_r <= {CW{1'b0}};
      end else if (en) begin
         if (cnt_r == LAST) begin
            cnt_r <= {CW{1'b0}};
         end else begin
            cnt_r <= cnt_r + ONE;
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign tick = (cnt_r == LAST);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Mux scan sequencer: steps the 8:1 mux select through channels 0..7, holding
// each for DWELL cycles, and assembles the sampled mux outputs into one byte.
module mux_scan_sequencer
   import mux_scan_defs::*;
#(
   parameter int DWELL = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             y_in,
   output logic [SEL_W-1:0] sel,
   output logic [NCH-1:0]   data,
   output logic             busy,
   output logic             done
);

   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NCH - 1);
   localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);

   state_t           state_r;
   logic [SEL_W-1:0] sel_r;
   logic [NCH-1:0]   shadow_r;
   logic [NCH-1:0]   data_r;
   logic             busy_r;
   logic             done_r;
   logic             tick_s;
   logic             tmr_clr_s;
   logic             tmr_en_s;
   logic [NCH-1:0]   shadow_nxt_s;

   // Timer control: runs only while scanning, held clear otherwise or on abort.
   always_comb begin
      tmr_en_s     = 1'b0;
      tmr_clr_s    = 1'b1;
      shadow_nxt_s = set_bit(shadow_r, sel_r, y_in);
      if (state_r == ST_SCAN) begin
         tmr_en_s  = 1'b1;
         tmr_clr_s = abort;
      end else begin
         tmr_en_s  = 1'b0;
         tmr_clr_s = 1'b1;
      end
   end

   dwell_timer #(
      .DWELL (DWELL)
   ) u_dwell_timer (
      .clk  (clk),
      .rst  (rst),
      .clr  (tmr_clr_s),
      .en   (tmr_en_s),
      .tick (tick_s)
   );

   // Scan FSM with registered select, shadow, result and status outputs.
   // The result byte and done are loaded on the edge entering DONE, so done
   // is high exactly while the DONE state is held and coincides with new data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         sel_r    <= {SEL_W{1'b0}};
         shadow_r <= {NCH{1'b0}};
         data_r   <= {NCH{1'b0}};
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (start && !abort) begin
                  state_r <= ST_SCAN;
                  sel_r   <= {SEL_W{1'b0}};
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end
            end
            ST_SCAN: begin
               if (abort) begin
                  state_r  <= ST_IDLE;
                  sel_r    <= {SEL_W{1'b0}};
                  shadow_r <= {NCH{1'b0}};
                  busy_r   <= 1'b0;
               end else if (tick_s) begin
                  shadow_r <= shadow_nxt_s;
                  if (sel_r == SEL_LAST) begin
                     state_r <= ST_DONE;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                     data_r  <= shadow_nxt_s;
                  end else begin
                     sel_r <= sel_r + SEL_ONE;
                  end
               end else begin
                  state_r <= ST_SCAN;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
               sel_r   <= {SEL_W{1'b0}};
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r  <= ST_IDLE;
               sel_r    <= {SEL_W{1'b0}};
               shadow_r <= {NCH{1'b0}};
               busy_r   <= 1'b0;
               done_r   <= 1'b0;
            end
         endcase
      end
   end

   assign sel  = sel_r;
   assign data = data_r;
   assign busy = busy_r;
   assign done = done_r;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench for mux_scan_sequencer: two instances (DWELL=1 and
// DWELL=3), each feeding an 8:1 mux model y = i[sel] back into y_in.
module tb_mux_scan_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start1, abort1, start3, abort3;
   logic [7:0] i1, i3;
   logic       y1, y3;
   logic [2:0] sel1, sel3;
   logic [7:0] data1, data3;
   logic       busy1, busy3, done1, done3;

   int n_checks = 0;
   int n_pass   = 0;
   int done_cnt1 = 0;

   always #5 clk = ~clk;

   // 8:1 mux models
   assign y1 = i1[sel1];
   assign y3 = i3[sel3];

   mux_scan_sequencer #(.DWELL(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .abort(abort1), .y_in(y1),
      .sel(sel1), .data(data1), .busy(busy1), .done(done1)
   );

   mux_scan_sequencer #(.DWELL(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .abort(abort3), .y_in(y3),
      .sel(sel3), .data(data3), .busy(busy3), .done(done3)
   );

   // count done pulses of the DWELL=1 instance
   always @(negedge clk) if (done1 === 1'b1) done_cnt1++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Pulse start on dut1, then walk the full scan checking sel/busy/done/data.
   task automatic scan1(input logic [7:0] pattern, input string tag);
      @(negedge clk); i1 = pattern; start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) @(negedge clk);
         check({tag, "_sel"}, 32'(sel1), 32'(k));
         check({tag, "_busy"}, 32'(busy1), 32'd1);
      end
      @(negedge clk);
      check({tag, "_done"}, 32'(done1), 32'd1);
      check({tag, "_busy_off"}, 32'(busy1), 32'd0);
      check({tag, "_data"}, 32'(data1), 32'(pattern));
      @(negedge clk);
      check({tag, "_done_off"}, 32'(done1), 32'd0);
   endtask

   initial begin
      rst = 1'b1; start1 = 1'b0; abort1 = 1'b0; start3 = 1'b0; abort3 = 1'b0;
      i1 = 8'h00; i3 = 8'h00;
      #1;
      check("rst_sel", 32'(sel1), 32'd0);
      check("rst_data", 32'(data1), 32'd0);
      check("rst_busy", 32'(busy1), 32'd0);
      check("rst_done", 32'(done1), 32'd0);
      check("rst3_data", 32'(data3), 32'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      // DWELL=1 basic scan
      scan1(8'hA5, "d1_a5");

      // DWELL=3 scan: each sel held 3 cycles, done at cycle 25
      @(negedge clk); i3 = 8'h3C; start3 = 1'b1;
      @(negedge clk); start3 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         for (int j = 0; j < 3; j++) begin
            if (k > 0 || j > 0) @(negedge clk);
            check("d3_sel", 32'(sel3), 32'(k));
            check("d3_busy", 32'(busy3), 32'd1);
            check("d3_done_low", 32'(done3), 32'd0);
         end
      end
      @(negedge clk);
      check("d3_done", 32'(done3), 32'd1);
      check("d3_data", 32'(data3), 32'h3C);
      check("d3_busy_off", 32'(busy3), 32'd0);
      @(negedge clk);
      check("d3_done_off", 32'(done3), 32'd0);

      // walking one, bit order
      for (int k = 0; k < 8; k++) scan1(8'h01 << k, "walk");

      // scan A5 then abort at sel=4
      scan1(8'hA5, "pre_abort");
      @(negedge clk); i1 = 8'hFF; start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      for (int k = 1; k <= 4; k++) @(negedge clk);
      check("abort_at_sel", 32'(sel1), 32'd4);
      abort1 = 1'b1;
      @(negedge clk); abort1 = 1'b0;
      check("abort_busy", 32'(busy1), 32'd0);
      check("abort_sel", 32'(sel1), 32'd0);
      check("abort_done", 32'(done1), 32'd0);
      check("abort_data", 32'(data1), 32'hA5);
      @(negedge clk);
      check("abort_idle_busy", 32'(busy1), 32'd0);
      check("abort_idle_done", 32'(done1), 32'd0);

      // start with abort in IDLE: stay idle
      start1 = 1'b1; abort1 = 1'b1;
      @(negedge clk); start1 = 1'b0; abort1 = 1'b0;
      check("start_abort_idle", 32'(busy1), 32'd0);

      // start during SCAN ignored
      done_cnt1 = 0;
      @(negedge clk); i1 = 8'h5A; start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      @(negedge clk); @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      for (int k = 0; k < 12; k++) @(negedge clk);
      check("restart_done_cnt", 32'(done_cnt1), 32'd1);
      check("restart_data", 32'(data1), 32'h5A);
      check("restart_idle", 32'(busy1), 32'd0);

      // reset mid-scan at sel=5
      @(negedge clk); i1 = 8'hC3; start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      for (int k = 1; k <= 5; k++) @(negedge clk);
      check("pre_rst_sel", 32'(sel1), 32'd5);
      #2 rst = 1'b1;
      #1;
      check("midrst_sel", 32'(sel1), 32'd0);
      check("midrst_data", 32'(data1), 32'd0);
      check("midrst_busy", 32'(busy1), 32'd0);
      check("midrst_done", 32'(done1), 32'd0);
      @(negedge clk); rst = 1'b0;
      scan1(8'h96, "post_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
